// File: rtl/register_file_pkg.sv
// Shared register-file sizing and architectural register names.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_ADDR_W   = 5;
  localparam int unsigned DEFAULT_NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/register_file_reg_word.sv
// One architectural register word: async active-high clear, enabled load.
module register_file_reg_word #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/register_file.sv
// MIPS GPR file: 32x32, two combinational read ports, one write port, $0 hardwired.
// Optional same-cycle write-to-read forwarding under `define REGFILE_BYPASS_EN.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // Write decoder: address 0 and unimplemented addresses never select a word
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      wr_sel[i] = wr_en && (rd_addr == ADDR_W'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < int'(NUM_REGS); g++) begin : g_word
    register_file_reg_word #(.DATA_W(DATA_W)) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (wr_sel[g]),
      .d     (wr_data),
      .q     (regs[g])
    );
  end

  logic [DATA_W-1:0] rs_mem;
  logic [DATA_W-1:0] rt_mem;

  // Read multiplexers; unmatched (unimplemented) addresses fall through to zero
  always_comb begin
    rs_mem = '0;
    rt_mem = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rs_addr == ADDR_W'(i)) rs_mem = regs[i];
      if (rt_addr == ADDR_W'(i)) rt_mem = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;

  // Forward only writes that will actually land in a register
  assign fwd_ok = !reset && (|wr_sel);

  always_comb begin
    rs_data = rs_mem;
    rt_data = rt_mem;
    if (fwd_ok && (rs_addr == rd_addr)) rs_data = wr_data;
    if (fwd_ok && (rt_addr == rd_addr)) rt_data = wr_data;
  end
`else
  assign rs_data = rs_mem;
  assign rt_data = rt_mem;
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, monitor checks on negedge.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rd_addr (rd_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per falling edge, against the current read outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rs_data !== e.rs || rt_data !== e.rt) begin
        errors++;
        $display("FAIL %s: rs_data=%h rt_data=%h expected rs=%h rt=%h",
                 e.name, rs_data, rt_data, e.rs, e.rt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input string nm);
    rs_addr = a;
    rt_addr = b;
    exp_q.push_back('{ea, eb, nm});
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    rd_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rs_addr = '0;
    rt_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    wr_en   = 1'b0;

    step();
    expect_rd(5'd1, 5'd31, 32'h0, 32'h0, "reset_state");
    step();
    reset = 1'b0;
    step();

    // Fill r1..r31 with all-ones
    for (int a = 1; a < 32; a++) write_reg(5'(a), 32'hFFFF_FFFF);
    expect_rd(5'd1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "fill_r1_r31");
    step();
    expect_rd(5'd17, 5'd30, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "fill_r17_r30");
    step();

    // Reset between edges clears immediately
    reset = 1'b1;
    expect_rd(5'd1, 5'd31, 32'h0, 32'h0, "reset_async_clear");
    step();
    expect_rd(5'd15, 5'd16, 32'h0, 32'h0, "reset_hold");
    step();
    reset = 1'b0;
    step();

    write_reg(5'd5, 32'h1234_5678);
    expect_rd(5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, "dual_port_same_reg");
    step();

    rs_addr = 5'd0;
    write_reg(5'd0, 32'hDEAD_BEEF);
    expect_rd(5'd0, 5'd5, 32'h0, 32'h1234_5678, "r0_write_discarded");
    step();

    // Read-during-write on r7
    write_reg(5'd7, 32'h0000_000A);
    wr_en   = 1'b1;
    rd_addr = 5'd7;
    wr_data = 32'h0000_000B;
`ifdef REGFILE_BYPASS_EN
    expect_rd(5'd7, 5'd0, 32'h0000_000B, 32'h0, "rdw_before_edge");
`else
    expect_rd(5'd7, 5'd0, 32'h0000_000A, 32'h0, "rdw_before_edge");
`endif
    step();
    wr_en = 1'b0;
    expect_rd(5'd7, 5'd7, 32'h0000_000B, 32'h0000_000B, "rdw_after_edge");
    step();

    wr_en   = 1'b0;
    rd_addr = 5'd9;
    wr_data = 32'h0000_0055;
    step();
    expect_rd(5'd9, 5'd5, 32'h0, 32'h1234_5678, "wr_en_low_no_write");
    step();

    write_reg(5'd31, 32'hCAFE_BABE);
    expect_rd(5'd31, 5'd30, 32'hCAFE_BABE, 32'h0, "r31_write");
    step();

    // Reset high on the same edge as a pending write to r3
    wr_en   = 1'b1;
    rd_addr = 5'd3;
    wr_data = 32'h0000_0077;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    expect_rd(5'd3, 5'd7, 32'h0, 32'h0, "write_dropped_by_reset");
    step();

    // Unknown write enable while held in reset
    reset   = 1'b1;
    wr_en   = 1'bx;
    rd_addr = 5'd4;
    wr_data = 32'h0000_0099;
    step();
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    expect_rd(5'd4, 5'd31, 32'h0, 32'h0, "x_wr_en_in_reset");
    step();

    write_reg(5'd12, 32'h8000_0001);
    expect_rd(5'd12, 5'd11, 32'h8000_0001, 32'h0, "msb_lsb_passthrough");
    step();

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
